// File: rtl/lamp_sequencer.sv
// Green-LED dashboard sequencer: decodes the meter state into chase, bounce and fill
// running-light patterns while moving, and a blink while waiting. Steps come from a programmable prescaler.
module lamp_sequencer #(
    parameter int unsigned N_LED = 8,
    parameter int unsigned DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       state,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic [DIV_W-1:0] period,
    output logic [N_LED-1:0] LED_G,
    output logic             step_pulse
);

    localparam int unsigned POS_W = $clog2(N_LED);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LED - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MOVE = 2'b01,
        ST_WAIT = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d, limit;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic               bdir_q, bdir_d;
    logic               blink_q, blink_d;
    logic [1:0]         mode_q;
    logic               dir_q;
    logic [N_LED-1:0]   led_q, led_d;
    logic               step_q, step_d;
    logic               tick;

    // LED image for a position: one-hot for chase/bounce, a bar anchored at the start end for fill
    function automatic logic [N_LED-1:0] pattern(input logic [POS_W-1:0] p,
                                                 input logic [1:0] m, input logic d);
        logic [N_LED-1:0] v;
        int unsigned      ip;
        v  = '0;
        ip = 32'(p);
        for (int unsigned i = 0; i < N_LED; i++) begin
            if (m == 2'b10) begin
                v[i] = d ? (i + ip >= N_LED - 1) : (i <= ip);
            end else begin
                v[i] = (i == ip);
            end
        end
        return v;
    endfunction

    always_comb begin
        case (state)
            2'b01:   state_d = ST_MOVE;
            2'b11:   state_d = ST_WAIT;
            default: state_d = ST_IDLE;
        endcase

        limit   = (period == '0) ? '0 : period - 1'b1;
        tick    = (div_q >= limit);
        pos_d   = pos_q;
        bdir_d  = bdir_q;
        blink_d = blink_q;
        div_d   = div_q;
        step_d  = 1'b0;

        if (state_d == ST_IDLE) begin
            pos_d   = '0;
            blink_d = 1'b0;
            div_d   = '0;
        end else if (state_d != state_q) begin
            // A state change always restarts the prescaler and suppresses any coincident step
            div_d = '0;
            if (state_d == ST_MOVE && state_q == ST_IDLE) begin
                bdir_d = dir;
                pos_d  = (dir && mode != 2'b10) ? POS_MAX : '0;
            end
            if (state_d == ST_WAIT) begin
                blink_d = 1'b1;
            end
        end else begin
            div_d  = tick ? '0 : div_q + 1'b1;
            step_d = tick;
            if (state_d == ST_MOVE) begin
                if (mode != mode_q || dir != dir_q) begin
                    bdir_d = dir;
                end
                if (tick) begin
                    case (mode)
                        2'b01: begin
                            if (!bdir_q) begin
                                if (pos_q == POS_MAX) begin
                                    bdir_d = 1'b1;
                                    pos_d  = POS_MAX - 1'b1;
                                end else begin
                                    pos_d = pos_q + 1'b1;
                                end
                            end else begin
                                if (pos_q == '0) begin
                                    bdir_d = 1'b0;
                                    pos_d  = POS_W'(1);
                                end else begin
                                    pos_d = pos_q - 1'b1;
                                end
                            end
                        end
                        2'b10: pos_d = (pos_q == POS_MAX) ? '0 : pos_q + 1'b1;
                        default: begin
                            if (dir) begin
                                pos_d = (pos_q == '0) ? POS_MAX : pos_q - 1'b1;
                            end else begin
                                pos_d = (pos_q == POS_MAX) ? '0 : pos_q + 1'b1;
                            end
                        end
                    endcase
                end
            end else if (tick) begin
                blink_d = ~blink_q;
            end
        end

        case (state_d)
            ST_IDLE: led_d = '0;
            ST_WAIT: led_d = {N_LED{blink_d}};
            default: led_d = pattern(pos_d, mode, dir);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            pos_q   <= '0;
            bdir_q  <= 1'b0;
            blink_q <= 1'b0;
            mode_q  <= 2'b00;
            dir_q   <= 1'b0;
            led_q   <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            pos_q   <= pos_d;
            bdir_q  <= bdir_d;
            blink_q <= blink_d;
            mode_q  <= mode;
            dir_q   <= dir;
            led_q   <= led_d;
            step_q  <= step_d;
        end
    end

    assign LED_G      = led_q;
    assign step_pulse = step_q;

endmodule
